depadding: RTL and testbench

Strips the zero-point border from a padded feature-map stream, so it is the inverse of the padding stage. It consumes row-major padded words and forwards only the interior pixels over a ready/valid master port. Inside a pixel, words are ordered by input-channel group. It sits after blocks that operate on padded maps, such as pooling and conv bypass paths, and restores the unpadded map for the next layer or for the DMA writer.

---
 rtl/depadding.sv | 163 ++++++++++++++++
 tb/tb_depadding.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/depadding.sv
// Strips the zero border from a row-major padded feature-map stream and forwards interior words only.
// Output is registered one cycle after an interior input handshake; input stalls while the output word is held.
module depadding #(
  parameter int CHANNEL_IN_NUM     = 16,
  parameter int WIDTH_DATA         = 8,
  parameter int PICTURE_NUM        = 2,
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int WIDTH_CHANNEL_NUM  = 10
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         Start,
  input  logic [WIDTH_FEATURE_SIZE-1:0]                Row_Num_In_REG,
  input  logic [WIDTH_CHANNEL_NUM-1:0]                 Channel_In_Num_REG,
  input  logic                                         Padding_REG,
  input  logic [2:0]                                   Zero_Num_REG,
  input  logic [WIDTH_DATA*PICTURE_NUM*CHANNEL_IN_NUM-1:0] S_Data,
  input  logic                                         S_Valid,
  output logic                                         S_Ready,
  output logic [WIDTH_DATA*PICTURE_NUM*CHANNEL_IN_NUM-1:0] M_Data,
  output logic                                         M_Valid,
  input  logic                                         M_Ready,
  output logic                                         Busy,
  output logic                                         Done
);

  localparam int W         = WIDTH_DATA * PICTURE_NUM * CHANNEL_IN_NUM;
  localparam int CIN_SHIFT = $clog2(CHANNEL_IN_NUM);
  localparam int WP        = WIDTH_FEATURE_SIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                         state;
  logic [WIDTH_CHANNEL_NUM-1:0]   ct;
  logic [WIDTH_FEATURE_SIZE-1:0]  n_cfg;
  logic [2:0]                     zl;
  logic [WP-1:0]                  p_side;
  logic [WP-1:0]                  lo;
  logic [WP-1:0]                  hi;
  logic [WIDTH_CHANNEL_NUM-1:0]   cnt_cin;
  logic [WP-1:0]                  cnt_col;
  logic [WP-1:0]                  cnt_row;
  logic [W-1:0]                   m_data_q;
  logic                           m_valid_q;
  logic                           busy_q;
  logic                           done_q;

  logic                           in_hs;
  logic                           interior;
  logic                           cin_wrap;
  logic                           col_wrap;
  logic                           last_word;
  logic [WIDTH_CHANNEL_NUM-1:0]   ct_last;
  logic [WP-1:0]                  p_last;

  assign S_Ready = (state == S_RUN) && (!m_valid_q || M_Ready);
  assign M_Data  = m_data_q;
  assign M_Valid = m_valid_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

  assign in_hs     = S_Valid && S_Ready;
  assign ct_last   = ct - WIDTH_CHANNEL_NUM'(1);
  assign p_last    = p_side - WP'(1);
  assign cin_wrap  = (cnt_cin == ct_last);
  assign col_wrap  = (cnt_col == p_last);
  assign last_word = cin_wrap && col_wrap && (cnt_row == p_last);
  assign interior  = (cnt_row >= lo) && (cnt_row <= hi) &&
                     (cnt_col >= lo) && (cnt_col <= hi);

  // Control FSM; Busy and Done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ct      <= '0;
      n_cfg   <= '0;
      zl      <= '0;
      p_side  <= '0;
      lo      <= '0;
      hi      <= '0;
      cnt_cin <= '0;
      cnt_col <= '0;
      cnt_row <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            ct     <= Channel_In_Num_REG >> CIN_SHIFT;
            n_cfg  <= Row_Num_In_REG;
            zl     <= Padding_REG ? Zero_Num_REG : 3'd0;
            busy_q <= 1'b1;
            state  <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          p_side <= WP'(n_cfg) + (WP'(zl) << 1);
          lo     <= WP'(zl);
          hi     <= WP'(zl) + WP'(n_cfg) - WP'(1);
          if (ct == '0 || n_cfg == '0) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_hs) begin
            if (cin_wrap) begin
              cnt_cin <= '0;
              if (col_wrap) begin
                cnt_col <= '0;
                cnt_row <= cnt_row + WP'(1);
              end else begin
                cnt_col <= cnt_col + WP'(1);
              end
            end else begin
              cnt_cin <= cnt_cin + WIDTH_CHANNEL_NUM'(1);
            end
            if (last_word) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Leave only once the final interior word has been taken downstream.
          if (!m_valid_q || M_Ready) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          cnt_cin <= '0;
          cnt_col <= '0;
          cnt_row <= '0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Single output register; a reload on the same cycle as an output handshake keeps M_Valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else if (in_hs && interior) begin
      m_data_q  <= S_Data;
      m_valid_q <= 1'b1;
    end else if (M_Ready) begin
      m_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_depadding.sv
// Randomized scoreboard bench for depadding: a pixel-coordinate reference model predicts interior words.
module tb_depadding;

  localparam int W = 8 * 2 * 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [11:0]  row_num;
  logic [9:0]   cin_num;
  logic         padding;
  logic [2:0]   zero_num;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         busy;
  logic         done;

  depadding dut (
    .clk                (clk),
    .rst                (rst),
    .Start              (start),
    .Row_Num_In_REG     (row_num),
    .Channel_In_Num_REG (cin_num),
    .Padding_REG        (padding),
    .Zero_Num_REG       (zero_num),
    .S_Data             (s_data),
    .S_Valid            (s_valid),
    .S_Ready            (s_ready),
    .M_Data             (m_data),
    .M_Valid            (m_valid),
    .M_Ready            (m_ready),
    .Busy               (busy),
    .Done               (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rmode = 0;
  int pat = 0;
  int first_in_cyc, last_in_cyc, last_out_cyc, done_cyc;
  int done_cnt = 0;
  bit prev_stall = 0;
  logic [W-1:0] prev_data;
  logic [W-1:0] words[$];
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = (pat == 0 || pat == 3);
          pat = (pat + 1) % 4;
        end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pops, backpressure rules, Done tracking.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", W'(m_valid), W'(1));
        chk("hold_data", m_data, prev_data);
      end
      if (m_valid && !m_ready) chk("stall_s_ready", W'(s_ready), W'(0));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", m_data, '0);
        end else begin
          chk("out_data", m_data, exp_q.pop_front());
        end
        last_out_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 0;
    end
  end

  // Reference model: word k belongs to pixel k/CT at (row, col) of a P x P map.
  task automatic build(input bit pad, input int z, input int n, input int cin);
    int zl, p, ct, pix, r, c;
    logic [W-1:0] w;
    words.delete();
    exp_q.delete();
    zl = pad ? z : 0;
    p  = n + 2 * zl;
    ct = cin / 16;
    for (int k = 0; k < p * p * ct; k++) begin
      for (int j = 0; j < W / 32; j++) w[j*32 +: 32] = (j == 0) ? k : $urandom;
      words.push_back(w);
      pix = k / ct;
      r = pix / p;
      c = pix % p;
      if (r >= zl && r < zl + n && c >= zl && c < zl + n) exp_q.push_back(w);
    end
  endtask

  task automatic start_cfg(input bit pad, input int z, input int n, input int cin);
    @(posedge clk);
    #1;
    padding  = pad;
    zero_num = 3'(z);
    row_num  = 12'(n);
    cin_num  = 10'(cin);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    padding  = 1'($urandom);
    zero_num = 3'($urandom);
    row_num  = 12'($urandom);
    cin_num  = 10'($urandom);
  endtask

  task automatic drive(input int vmode, input int limit, output int nin);
    int guard = 0;
    nin = 0;
    while (nin < limit && guard < 20000) begin
      @(posedge clk);
      #1;
      s_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s_data  = words[nin];
      @(negedge clk);
      if (s_valid && s_ready) begin
        if (nin == 0) first_in_cyc = cyc;
        last_in_cyc = cyc;
        nin++;
      end
      guard++;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic run_map(input string name, input bit pad, input int z, input int n,
                         input int cin, input int vmode, input int rm);
    int d0, nin, exp_done;
    rmode = rm;
    build(pad, z, n, cin);
    d0 = done_cnt;
    last_out_cyc = -100;
    start_cfg(pad, z, n, cin);
    drive(vmode, words.size(), nin);
    chk({name, "_inputs"}, W'(nin), W'(words.size()));
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      @(negedge clk);
      #1;
    end
    chk({name, "_done_cnt"}, W'(done_cnt), W'(d0 + 1));
    chk({name, "_left"}, W'(exp_q.size()), W'(0));
    exp_done = (last_in_cyc + 2 > last_out_cyc + 1) ? last_in_cyc + 2 : last_out_cyc + 1;
    chk({name, "_done_time"}, W'(done_cyc), W'(exp_done));
    if (vmode == 0 && rm == 0) chk({name, "_rate"}, W'(last_in_cyc - first_in_cyc), W'(nin - 1));
    repeat (3) @(negedge clk);
    chk({name, "_single_done"}, W'(done_cnt), W'(d0 + 1));
    chk({name, "_idle"}, W'(busy), W'(0));
  endtask

  initial begin
    int nin, d0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    padding = 1'b0; zero_num = '0; row_num = '0; cin_num = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", W'(s_ready), W'(0));
    chk("rst_m_valid", W'(m_valid), W'(0));
    chk("rst_m_data", m_data, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    #1 rst = 1'b0;

    run_map("pass", 1'b0, 3, 4, 32, 0, 0);
    run_map("z1n3", 1'b1, 1, 3, 16, 0, 0);
    run_map("z2n2", 1'b1, 2, 2, 48, 1, 2);
    run_map("bp", 1'b1, 1, 3, 16, 1, 1);

    // Abort a map part way through with a reset.
    rmode = 2;
    build(1'b1, 2, 2, 48);
    d0 = done_cnt;
    start_cfg(1'b1, 2, 2, 48);
    drive(1, 10, nin);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", W'(busy), W'(0));
    chk("rst_mid_m_valid", W'(m_valid), W'(0));
    chk("rst_mid_s_ready", W'(s_ready), W'(0));
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("rst_mid_no_done", W'(done_cnt), W'(d0));
    run_map("after_rst", 1'b1, 1, 3, 16, 1, 2);

    // CT == 0: straight to Done without touching the stream.
    @(posedge clk);
    #1;
    cin_num = 10'd8; row_num = 12'd3; padding = 1'b1; zero_num = 3'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("deg_busy1", W'({busy, done, s_ready}), W'(3'b100));
    @(negedge clk);
    chk("deg_busy2", W'({busy, done, s_ready}), W'(3'b110));
    @(negedge clk);
    chk("deg_idle", W'({busy, done, s_ready}), W'(3'b000));

    for (int t = 0; t < 4; t++) begin
      run_map("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 5),
              16 * $urandom_range(1, 3), $urandom_range(0, 1), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
